axil_regfile: RTL and testbench

- Parametrised AXI4-Lite slave register bank: NUM_REGS words of DATA_WIDTH bits, byte-strobe writes, per-register read-only mask, all register contents exported to fabric.
- Successor to the fixed 6-word slave. Adds independent AW/W acceptance, WSTRB merging, word-aligned decode, read-only protection and exported registers.
- Sits behind the AXI-Lite interconnect as the configuration/status block for the mouse-controller datapath.

---
 rtl/axil_regfile_pkg.sv | 34 +++
 rtl/axil_strb_merge.sv | 21 ++
 rtl/axil_regfile.sv | 247 ++++++++++++++++++++++++
 tb/tb_axil_regfile.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/axil_regfile_pkg.sv
// Shared definitions for the AXI4-Lite register bank: response codes, FSM state
// encodings and a constant log2 helper.
package axil_regfile_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        W_IDLE      = 3'd0,
        W_ADDR_HELD = 3'd1,
        W_DATA_HELD = 3'd2,
        W_COMMIT    = 3'd3,
        W_RESP      = 3'd4
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rstate_t;

    // Ceiling log2 for elaboration-time sizing.
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axil_strb_merge.sv
// Byte-strobe merge: each byte with its strobe set takes the new word, others keep the old word.
module axil_strb_merge
    import axil_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   old_word,
    input  logic [DATA_WIDTH-1:0]   new_word,
    input  logic [DATA_WIDTH/8-1:0] strb,
    output logic [DATA_WIDTH-1:0]   merged
);

    // Per-byte select between old and new data.
    always_comb begin
        merged = old_word;
        for (int b = 0; b < DATA_WIDTH / 8; b++) begin
            merged[b*8 +: 8] = strb[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
        end
    end

endmodule

// File: rtl/axil_regfile.sv
// Parametrised AXI4-Lite slave register bank with byte strobes, read-only mask and exported registers.
// Optional macro AXIL_REGFILE_WR_PULSE_EN adds a per-register one-cycle write pulse output.
module axil_regfile
    import axil_regfile_pkg::*;
#(
    parameter int                  ADDR_WIDTH = 8,
    parameter int                  DATA_WIDTH = 32,
    parameter int                  NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic [2:0]                     AWPROT,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic [2:0]                     ARPROT,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_d
`ifdef AXIL_REGFILE_WR_PULSE_EN
    ,
    output logic [NUM_REGS-1:0]            wr_pulse
`endif
);

    localparam int ADDR_LSB = clog2(DATA_WIDTH / 8);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam int STRB_W   = DATA_WIDTH / 8;

    wstate_t                       wstate_r;
    rstate_t                       rstate_r;
    logic                          aw_ready_r;
    logic                          w_ready_r;
    logic                          bvalid_r;
    logic [1:0]                    bresp_r;
    logic                          ar_ready_r;
    logic                          rvalid_r;
    logic [1:0]                    rresp_r;
    logic [DATA_WIDTH-1:0]         rdata_r;
    logic [IDX_W-1:0]              aw_idx_r;
    logic [DATA_WIDTH-1:0]         wdata_r;
    logic [STRB_W-1:0]             wstrb_r;
    logic [NUM_REGS*DATA_WIDTH-1:0] regs_r;

    logic                          aw_hs_s;
    logic                          w_hs_s;
    logic                          ar_hs_s;
    logic [IDX_W-1:0]              rd_idx_s;
    logic [NUM_REGS-1:0]           wr_hit_s;
    logic [NUM_REGS-1:0]           rd_hit_s;
    logic                          wr_err_s;
    logic                          rd_err_s;
    logic [DATA_WIDTH-1:0]         old_word_s;
    logic [DATA_WIDTH-1:0]         merged_s;
    logic [DATA_WIDTH-1:0]         rd_word_s;
    logic                          unused_s;

    assign aw_hs_s  = AWVALID & aw_ready_r;
    assign w_hs_s   = WVALID & w_ready_r;
    assign ar_hs_s  = ARVALID & ar_ready_r;
    assign rd_idx_s = ARADDR[ADDR_WIDTH-1:ADDR_LSB];
    assign unused_s = ^{AWPROT, ARPROT, AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0]};

    // Word decode and data muxing; an index with no matching word is out of range.
    always_comb begin
        wr_hit_s   = '0;
        rd_hit_s   = '0;
        old_word_s = '0;
        rd_word_s  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_hit_s[i] = (32'(aw_idx_r) == 32'(i));
            rd_hit_s[i] = (32'(rd_idx_s) == 32'(i));
            old_word_s  = old_word_s | ({DATA_WIDTH{wr_hit_s[i]}} & regs_r[i*DATA_WIDTH +: DATA_WIDTH]);
            rd_word_s   = rd_word_s | ({DATA_WIDTH{rd_hit_s[i]}} &
                          (RO_MASK[i] ? ro_d[i*DATA_WIDTH +: DATA_WIDTH] : regs_r[i*DATA_WIDTH +: DATA_WIDTH]));
        end
        wr_err_s = ~(|wr_hit_s) | (|(wr_hit_s & RO_MASK));
        rd_err_s = ~(|rd_hit_s);
    end

    axil_strb_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_strb_merge (
        .old_word (old_word_s),
        .new_word (wdata_r),
        .strb     (wstrb_r),
        .merged   (merged_s)
    );

    // Write FSM: independent AW/W capture, one-cycle commit, then response hold.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wstate_r   <= W_IDLE;
            aw_ready_r <= 1'b0;
            w_ready_r  <= 1'b0;
            bvalid_r   <= 1'b0;
            bresp_r    <= RESP_OKAY;
            aw_idx_r   <= '0;
            wdata_r    <= '0;
            wstrb_r    <= '0;
            regs_r     <= '0;
        end else begin
            case (wstate_r)
                W_IDLE: begin
                    if (aw_hs_s) aw_idx_r <= AWADDR[ADDR_WIDTH-1:ADDR_LSB];
                    if (w_hs_s) begin
                        wdata_r <= WDATA;
                        wstrb_r <= WSTRB;
                    end
                    if (aw_hs_s && w_hs_s) begin
                        aw_ready_r <= 1'b0;
                        w_ready_r  <= 1'b0;
                        wstate_r   <= W_COMMIT;
                    end else if (aw_hs_s) begin
                        aw_ready_r <= 1'b0;
                        w_ready_r  <= 1'b1;
                        wstate_r   <= W_ADDR_HELD;
                    end else if (w_hs_s) begin
                        aw_ready_r <= 1'b1;
                        w_ready_r  <= 1'b0;
                        wstate_r   <= W_DATA_HELD;
                    end else begin
                        // Readies are low only on the first cycle out of reset.
                        aw_ready_r <= 1'b1;
                        w_ready_r  <= 1'b1;
                    end
                end
                W_ADDR_HELD: begin
                    if (w_hs_s) begin
                        wdata_r   <= WDATA;
                        wstrb_r   <= WSTRB;
                        w_ready_r <= 1'b0;
                        wstate_r  <= W_COMMIT;
                    end
                end
                W_DATA_HELD: begin
                    if (aw_hs_s) begin
                        aw_idx_r   <= AWADDR[ADDR_WIDTH-1:ADDR_LSB];
                        aw_ready_r <= 1'b0;
                        wstate_r   <= W_COMMIT;
                    end
                end
                W_COMMIT: begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (wr_hit_s[i] && !wr_err_s) regs_r[i*DATA_WIDTH +: DATA_WIDTH] <= merged_s;
                    end
                    bresp_r  <= wr_err_s ? RESP_SLVERR : RESP_OKAY;
                    bvalid_r <= 1'b1;
                    wstate_r <= W_RESP;
                end
                W_RESP: begin
                    if (BREADY) begin
                        bvalid_r   <= 1'b0;
                        aw_ready_r <= 1'b1;
                        w_ready_r  <= 1'b1;
                        wstate_r   <= W_IDLE;
                    end
                end
                default: begin
                    aw_ready_r <= 1'b0;
                    w_ready_r  <= 1'b0;
                    bvalid_r   <= 1'b0;
                    wstate_r   <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: register the response on the address handshake and hold it until accepted.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rstate_r   <= R_IDLE;
            ar_ready_r <= 1'b0;
            rvalid_r   <= 1'b0;
            rresp_r    <= RESP_OKAY;
            rdata_r    <= '0;
        end else begin
            case (rstate_r)
                R_IDLE: begin
                    if (ar_hs_s) begin
                        rdata_r    <= rd_word_s;
                        rresp_r    <= rd_err_s ? RESP_SLVERR : RESP_OKAY;
                        rvalid_r   <= 1'b1;
                        ar_ready_r <= 1'b0;
                        rstate_r   <= R_RESP;
                    end else begin
                        ar_ready_r <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (RREADY) begin
                        rvalid_r   <= 1'b0;
                        ar_ready_r <= 1'b1;
                        rstate_r   <= R_IDLE;
                    end
                end
                default: begin
                    rvalid_r   <= 1'b0;
                    ar_ready_r <= 1'b0;
                    rstate_r   <= R_IDLE;
                end
            endcase
        end
    end

`ifdef AXIL_REGFILE_WR_PULSE_EN
    logic [NUM_REGS-1:0] wr_pulse_r;

    // One-cycle strobe after every successful commit, strobe-less writes included.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_pulse_r <= '0;
        end else if (wstate_r == W_COMMIT && !wr_err_s) begin
            wr_pulse_r <= wr_hit_s;
        end else begin
            wr_pulse_r <= '0;
        end
    end

    assign wr_pulse = wr_pulse_r;
`endif

    assign AWREADY = aw_ready_r;
    assign WREADY  = w_ready_r;
    assign BVALID  = bvalid_r;
    assign BRESP   = bresp_r;
    assign ARREADY = ar_ready_r;
    assign RVALID  = rvalid_r;
    assign RRESP   = rresp_r;
    assign RDATA   = rdata_r;
    assign reg_q   = regs_r;

endmodule

// File: tb/tb_axil_regfile.sv
// Directed self-checking bench for axil_regfile (NUM_REGS=8, RO_MASK=0x80, 32-bit data).
module tb_axil_regfile;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic [7:0]   AWADDR;
    logic [2:0]   AWPROT;
    logic         AWVALID;
    logic         AWREADY;
    logic [31:0]  WDATA;
    logic [3:0]   WSTRB;
    logic         WVALID;
    logic         WREADY;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY;
    logic [7:0]   ARADDR;
    logic [2:0]   ARPROT;
    logic         ARVALID;
    logic         ARREADY;
    logic [31:0]  RDATA;
    logic [1:0]   RRESP;
    logic         RVALID;
    logic         RREADY;
    logic [255:0] reg_q;
    logic [255:0] ro_d;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_regs [8];

    logic        bv0, bv1, rv;
    logic [1:0]  br, rr;
    logic [31:0] rd_data;

    axil_regfile #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .NUM_REGS   (8),
        .RO_MASK    (8'h80)
    ) dut (
        .ACLK (ACLK), .ARESET (ARESET),
        .AWADDR (AWADDR), .AWPROT (AWPROT), .AWVALID (AWVALID), .AWREADY (AWREADY),
        .WDATA (WDATA), .WSTRB (WSTRB), .WVALID (WVALID), .WREADY (WREADY),
        .BRESP (BRESP), .BVALID (BVALID), .BREADY (BREADY),
        .ARADDR (ARADDR), .ARPROT (ARPROT), .ARVALID (ARVALID), .ARREADY (ARREADY),
        .RDATA (RDATA), .RRESP (RRESP), .RVALID (RVALID), .RREADY (RREADY),
        .reg_q (reg_q), .ro_d (ro_d)
    );

    always #5 ACLK = ~ACLK;

    function automatic logic [255:0] exp_flat();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = exp_regs[i];
        return v;
    endfunction

    // Same-cycle AW+W write; reports BVALID one and two edges after the handshake.
    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic o_bv0, output logic o_bv1, output logic [1:0] o_br);
        @(posedge ACLK); #1;
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        @(negedge ACLK); o_bv0 = BVALID;
        @(negedge ACLK); o_bv1 = BVALID; o_br = BRESP;
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic o_rv, output logic [31:0] o_d, output logic [1:0] o_r);
        @(posedge ACLK); #1;
        ARADDR = a; ARVALID = 1'b1;
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        @(negedge ACLK); o_rv = RVALID; o_d = RDATA; o_r = RRESP;
        RREADY = 1'b1;
        @(posedge ACLK); #1;
        RREADY = 1'b0;
    endtask

    task automatic test_reset();
        ARESET = 1'b1; AWADDR = 8'h00; AWPROT = 3'd0; AWVALID = 1'b0; WDATA = 32'h0; WSTRB = 4'h0;
        WVALID = 1'b0; BREADY = 1'b0; ARADDR = 8'h00; ARPROT = 3'd0; ARVALID = 1'b0; RREADY = 1'b0;
        ro_d = '0; ro_d[7*32 +: 32] = 32'hCAFE0001;
        for (int i = 0; i < 8; i++) exp_regs[i] = 32'h0;
        #12;
        n_vec++; if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin n_err++; $display("FAIL rst_readies got %b exp 000", {AWREADY, WREADY, ARREADY}); end
        n_vec++; if ({BVALID, RVALID, BRESP, RRESP} !== 6'b0) begin n_err++; $display("FAIL rst_resp got %b exp 0", {BVALID, RVALID, BRESP, RRESP}); end
        n_vec++; if (RDATA !== 32'h0) begin n_err++; $display("FAIL rst_rdata got %h exp 0", RDATA); end
        n_vec++; if (reg_q !== 256'h0) begin n_err++; $display("FAIL rst_regq got %h exp 0", reg_q); end
        @(posedge ACLK); #1; ARESET = 1'b0;
        @(negedge ACLK);
        n_vec++; if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin n_err++; $display("FAIL rel_readies_early got %b exp 000", {AWREADY, WREADY, ARREADY}); end
        @(negedge ACLK);
        n_vec++; if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin n_err++; $display("FAIL rel_readies got %b exp 111", {AWREADY, WREADY, ARREADY}); end
    endtask

    task automatic test_write_same_cycle();
        wr(8'h04, 32'hDEADBEEF, 4'hF, bv0, bv1, br);
        exp_regs[1] = 32'hDEADBEEF;
        n_vec++; if (bv0 !== 1'b0) begin n_err++; $display("FAIL sc_bvalid_early got %b exp 0", bv0); end
        n_vec++; if (bv1 !== 1'b1) begin n_err++; $display("FAIL sc_bvalid got %b exp 1", bv1); end
        n_vec++; if (br !== 2'b00) begin n_err++; $display("FAIL sc_bresp got %b exp 00", br); end
        n_vec++; if (reg_q !== exp_flat()) begin n_err++; $display("FAIL sc_regq got %h exp %h", reg_q, exp_flat()); end
        rd(8'h04, rv, rd_data, rr);
        n_vec++; if ({rv, rd_data, rr} !== {1'b1, 32'hDEADBEEF, 2'b00}) begin n_err++; $display("FAIL sc_read got %b %h %b exp 1 deadbeef 00", rv, rd_data, rr); end
        rd(8'h07, rv, rd_data, rr);
        n_vec++; if ({rv, rd_data, rr} !== {1'b1, 32'hDEADBEEF, 2'b00}) begin n_err++; $display("FAIL sc_read_lowbits got %b %h %b exp 1 deadbeef 00", rv, rd_data, rr); end
    endtask

    task automatic test_w_before_aw();
        wr(8'h08, 32'hAAAAAAAA, 4'hF, bv0, bv1, br);
        @(posedge ACLK); #1;
        WDATA = 32'h12345678; WSTRB = 4'h3; WVALID = 1'b1;
        @(posedge ACLK); #1;
        WVALID = 1'b0;
        @(negedge ACLK);
        n_vec++; if ({WREADY, AWREADY, BVALID} !== 3'b010) begin n_err++; $display("FAIL wfirst_held got %b exp 010", {WREADY, AWREADY, BVALID}); end
        repeat (2) @(posedge ACLK);
        #1; AWADDR = 8'h08; AWVALID = 1'b1;
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        @(negedge ACLK);
        n_vec++; if (BVALID !== 1'b0) begin n_err++; $display("FAIL wfirst_bvalid_early got %b exp 0", BVALID); end
        @(negedge ACLK);
        n_vec++; if ({BVALID, BRESP} !== 3'b100) begin n_err++; $display("FAIL wfirst_bresp got %b exp 100", {BVALID, BRESP}); end
        exp_regs[2] = 32'hAAAA5678;
        n_vec++; if (reg_q !== exp_flat()) begin n_err++; $display("FAIL wfirst_regq got %h exp %h", reg_q, exp_flat()); end
        BREADY = 1'b1;
        @(posedge ACLK); #1; BREADY = 1'b0;
        repeat (2) @(negedge ACLK);
        n_vec++; if ({BVALID, AWREADY, WREADY} !== 3'b011) begin n_err++; $display("FAIL wfirst_single got %b exp 011", {BVALID, AWREADY, WREADY}); end
    endtask

    task automatic test_wstrb_zero();
        wr(8'h0C, 32'hFFFFFFFF, 4'h0, bv0, bv1, br);
        n_vec++; if ({bv1, br} !== 3'b100) begin n_err++; $display("FAIL strb0_bresp got %b exp 100", {bv1, br}); end
        n_vec++; if (reg_q !== exp_flat()) begin n_err++; $display("FAIL strb0_regq got %h exp %h", reg_q, exp_flat()); end
    endtask

    task automatic test_out_of_range();
        wr(8'h20, 32'h55555555, 4'hF, bv0, bv1, br);
        n_vec++; if ({bv1, br} !== 3'b110) begin n_err++; $display("FAIL oor_bresp got %b exp 110", {bv1, br}); end
        n_vec++; if (reg_q !== exp_flat()) begin n_err++; $display("FAIL oor_regq got %h exp %h", reg_q, exp_flat()); end
        rd(8'h20, rv, rd_data, rr);
        n_vec++; if ({rv, rd_data, rr} !== {1'b1, 32'h0, 2'b10}) begin n_err++; $display("FAIL oor_read got %b %h %b exp 1 0 10", rv, rd_data, rr); end
        rd(8'hFC, rv, rd_data, rr);
        n_vec++; if ({rv, rd_data, rr} !== {1'b1, 32'h0, 2'b10}) begin n_err++; $display("FAIL oor_read_top got %b %h %b exp 1 0 10", rv, rd_data, rr); end
    endtask

    task automatic test_read_only();
        wr(8'h1C, 32'h11111111, 4'hF, bv0, bv1, br);
        n_vec++; if ({bv1, br} !== 3'b110) begin n_err++; $display("FAIL ro_bresp got %b exp 110", {bv1, br}); end
        n_vec++; if (reg_q !== exp_flat()) begin n_err++; $display("FAIL ro_regq got %h exp %h", reg_q, exp_flat()); end
        rd(8'h1C, rv, rd_data, rr);
        n_vec++; if ({rv, rd_data, rr} !== {1'b1, 32'hCAFE0001, 2'b00}) begin n_err++; $display("FAIL ro_read got %b %h %b exp 1 cafe0001 00", rv, rd_data, rr); end
    endtask

    task automatic test_rw_collision();
        @(posedge ACLK); #1;
        AWADDR = 8'h00; WDATA = 32'h00000001; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0; ARADDR = 8'h00; ARVALID = 1'b1;
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        @(negedge ACLK);
        exp_regs[0] = 32'h00000001;
        n_vec++; if ({RVALID, RDATA} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL coll_read got %b %h exp 1 0", RVALID, RDATA); end
        n_vec++; if ({BVALID, reg_q} !== {1'b1, exp_flat()}) begin n_err++; $display("FAIL coll_write got %b %h exp 1 %h", BVALID, reg_q, exp_flat()); end
        BREADY = 1'b1; RREADY = 1'b1;
        @(posedge ACLK); #1; BREADY = 1'b0; RREADY = 1'b0;
    endtask

    task automatic test_backpressure();
        @(posedge ACLK); #1;
        AWADDR = 8'h0C; WDATA = 32'h000000FF; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        @(posedge ACLK); #1;
        WVALID = 1'b0; AWADDR = 8'h10;
        repeat (2) @(negedge ACLK);
        for (int c = 0; c < 5; c++) begin
            n_vec++; if ({BVALID, BRESP, AWREADY, WREADY} !== 5'b10000) begin n_err++; $display("FAIL bp_write c%0d got %b exp 10000", c, {BVALID, BRESP, AWREADY, WREADY}); end
            @(negedge ACLK);
        end
        AWVALID = 1'b0; BREADY = 1'b1;
        @(posedge ACLK); #1; BREADY = 1'b0;
        exp_regs[3] = 32'h000000FF;
        n_vec++; if (reg_q !== exp_flat()) begin n_err++; $display("FAIL bp_regq got %h exp %h", reg_q, exp_flat()); end
        @(posedge ACLK); #1;
        ARADDR = 8'h04; ARVALID = 1'b1;
        @(posedge ACLK); #1;
        ARADDR = 8'h08;
        for (int c = 0; c < 5; c++) begin
            @(negedge ACLK);
            n_vec++; if ({RVALID, RDATA, RRESP, ARREADY} !== {1'b1, 32'hDEADBEEF, 2'b00, 1'b0}) begin n_err++; $display("FAIL bp_read c%0d got %b %h %b %b exp 1 deadbeef 00 0", c, RVALID, RDATA, RRESP, ARREADY); end
        end
        ARVALID = 1'b0; RREADY = 1'b1;
        @(posedge ACLK); #1; RREADY = 1'b0;
        @(negedge ACLK);
        n_vec++; if ({RVALID, ARREADY} !== 2'b01) begin n_err++; $display("FAIL bp_read_done got %b exp 01", {RVALID, ARREADY}); end
    endtask

    task automatic test_reset_midtxn();
        @(posedge ACLK); #1;
        WDATA = 32'hBADBAD00; WSTRB = 4'hF; WVALID = 1'b1;
        @(posedge ACLK); #1;
        WVALID = 1'b0;
        #2; ARESET = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) exp_regs[i] = 32'h0;
        n_vec++; if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0) begin n_err++; $display("FAIL mid_rst_ctrl got %b exp 00000", {AWREADY, WREADY, ARREADY, BVALID, RVALID}); end
        n_vec++; if ({BRESP, RRESP, RDATA} !== 36'h0) begin n_err++; $display("FAIL mid_rst_data got %h exp 0", {BRESP, RRESP, RDATA}); end
        n_vec++; if (reg_q !== 256'h0) begin n_err++; $display("FAIL mid_rst_regq got %h exp 0", reg_q); end
        repeat (2) @(posedge ACLK);
        #1; ARESET = 1'b0;
        wr(8'h10, 32'h5A5A5A5A, 4'hF, bv0, bv1, br);
        exp_regs[4] = 32'h5A5A5A5A;
        n_vec++; if ({bv0, bv1, br} !== 4'b0100) begin n_err++; $display("FAIL post_rst_write got %b exp 0100", {bv0, bv1, br}); end
        n_vec++; if (reg_q !== exp_flat()) begin n_err++; $display("FAIL post_rst_regq got %h exp %h", reg_q, exp_flat()); end
    endtask

    initial begin
        test_reset();
        test_write_same_cycle();
        test_w_before_aw();
        test_wstrb_zero();
        test_out_of_range();
        test_read_only();
        test_rw_collision();
        test_backpressure();
        test_reset_midtxn();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
